// File: rtl/dcache_wt_ctrl.sv
// dcache_wt_ctrl
//   Direct-mapped, write-through, no-write-allocate data cache controller
//   between the CPU load/store port and the data memory block. Cacheable read
//   hits are answered locally in one cycle. Misses, uncached reads and every
//   write go to memory over the mem_req_valid/mem_ready handshake. Hit and miss
//   counters cover cacheable reads only.
//
//   Cacheable regions: 0x200..0x3FC (const) and 0x800..0x9FC (var).
//
// Ports
//   CLK, RESET          clock (rising edge), asynchronous active-high reset
//   cpu_req_valid       CPU request, held with rw/addr/wdata until cpu_done
//   cpu_req_rw          1 = write, 0 = read
//   cpu_addr            byte address, bits [1:0] ignored
//   cpu_wdata           store data
//   cpu_rdata           load data, valid while cpu_done = 1
//   cpu_done            one-cycle completion pulse
//   flush               clears every line valid bit at the next edge
//   mem_req_valid       registered memory request
//   mem_req_rw          1 = write, 0 = read
//   mem_req_addr        word-aligned request address
//   mem_data_write      store data to memory
//   mem_data_read       memory read data, valid with mem_ready
//   mem_ready           one-cycle memory completion
//   hit_count           cacheable read hits (wraps)
//   miss_count          cacheable read misses (wraps)
module dcache_wt_ctrl #(
  parameter int IDX_BITS = 3,
  parameter int CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             cpu_req_valid,
  input  logic             cpu_req_rw,
  input  logic [31:0]      cpu_addr,
  input  logic [31:0]      cpu_wdata,
  output logic [31:0]      cpu_rdata,
  output logic             cpu_done,
  input  logic             flush,
  output logic             mem_req_valid,
  output logic             mem_req_rw,
  output logic [31:0]      mem_req_addr,
  output logic [31:0]      mem_data_write,
  input  logic [31:0]      mem_data_read,
  input  logic             mem_ready,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int N_LINES = 1 << IDX_BITS;
  localparam int TAG_W   = 30 - IDX_BITS;

  typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU} state_t;

  state_t state, state_next;

  logic [N_LINES-1:0] line_valid;
  logic [TAG_W-1:0]   line_tag  [N_LINES];
  logic [31:0]        line_data [N_LINES];

  logic [IDX_BITS-1:0] cpu_idx, req_idx;
  logic [TAG_W-1:0]    cpu_tag, req_tag;
  logic cpu_var, cpu_cacheable, cpu_hit, accept;
  logic req_var, req_cacheable;

  logic        done_next, mvalid_next, mrw_next;
  logic [31:0] rdata_next, maddr_next, mwdata_next;
  logic        hit_inc, miss_inc, fill_en, upd_en, clear_all;

  // Byte-offset bits never take part in lookup or in the memory address.
  logic unused_addr_bits;
  assign unused_addr_bits = ^cpu_addr[1:0];

  assign cpu_idx       = cpu_addr[2 +: IDX_BITS];
  assign cpu_tag       = cpu_addr[31:2+IDX_BITS];
  assign cpu_var       = (cpu_addr[31:9] == 23'd4);
  assign cpu_cacheable = (cpu_addr[31:9] == 23'd1) || cpu_var;
  assign cpu_hit       = cpu_cacheable && line_valid[cpu_idx] && (line_tag[cpu_idx] == cpu_tag);
  assign accept        = (state == IDLE) && cpu_req_valid && !cpu_done;

  // While a request is outstanding, fill and coherence decisions use the
  // registered request address so they do not depend on the CPU holding it.
  assign req_idx       = mem_req_addr[2 +: IDX_BITS];
  assign req_tag       = mem_req_addr[31:2+IDX_BITS];
  assign req_var       = (mem_req_addr[31:9] == 23'd4);
  assign req_cacheable = (mem_req_addr[31:9] == 23'd1) || req_var;

  always_comb begin
    state_next  = state;
    done_next   = 1'b0;
    rdata_next  = cpu_rdata;
    mvalid_next = mem_req_valid;
    mrw_next    = mem_req_rw;
    maddr_next  = mem_req_addr;
    mwdata_next = mem_data_write;
    hit_inc     = 1'b0;
    miss_inc    = 1'b0;
    fill_en     = 1'b0;
    upd_en      = 1'b0;
    clear_all   = flush;

    case (state)
      IDLE: begin
        if (accept) begin
          if (cpu_req_rw) begin
            mvalid_next = 1'b1;
            mrw_next    = 1'b1;
            maddr_next  = {cpu_addr[31:2], 2'b00};
            mwdata_next = cpu_wdata;
            upd_en      = cpu_var && cpu_hit;
            state_next  = WR_THRU;
          end else if (cpu_hit) begin
            rdata_next = line_data[cpu_idx];
            done_next  = 1'b1;
            hit_inc    = 1'b1;
          end else begin
            mvalid_next = 1'b1;
            mrw_next    = 1'b0;
            maddr_next  = {cpu_addr[31:2], 2'b00};
            miss_inc    = cpu_cacheable;
            state_next  = RD_MISS;
          end
        end
      end

      RD_MISS: begin
        if (mem_ready) begin
          mvalid_next = 1'b0;
          rdata_next  = mem_data_read;
          done_next   = 1'b1;
          // A coincident flush wins: the CPU gets its data, the line stays invalid.
          fill_en     = req_cacheable && !flush;
          state_next  = IDLE;
        end
      end

      WR_THRU: begin
        if (mem_ready) begin
          mvalid_next = 1'b0;
          done_next   = 1'b1;
          // Memory folds any non-var write onto var storage, so which cached
          // word went stale is unknown; drop the whole cache.
          if (!req_var) clear_all = 1'b1;
          state_next  = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state          <= IDLE;
      cpu_done       <= 1'b0;
      cpu_rdata      <= '0;
      mem_req_valid  <= 1'b0;
      mem_req_rw     <= 1'b0;
      mem_req_addr   <= '0;
      mem_data_write <= '0;
      hit_count      <= '0;
      miss_count     <= '0;
    end else begin
      state          <= state_next;
      cpu_done       <= done_next;
      cpu_rdata      <= rdata_next;
      mem_req_valid  <= mvalid_next;
      mem_req_rw     <= mrw_next;
      mem_req_addr   <= maddr_next;
      mem_data_write <= mwdata_next;
      if (hit_inc)  hit_count  <= hit_count + CNT_W'(1);
      if (miss_inc) miss_count <= miss_count + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      line_valid <= '0;
    end else if (clear_all) begin
      line_valid <= '0;
    end else if (fill_en) begin
      line_valid[req_idx] <= 1'b1;
    end
  end

  // Tag and data need no reset; they are only trusted behind a valid bit.
  always_ff @(posedge CLK) begin
    if (fill_en) begin
      line_tag[req_idx]  <= req_tag;
      line_data[req_idx] <= mem_data_read;
    end else if (upd_en) begin
      line_data[cpu_idx] <= cpu_wdata;
    end
  end

endmodule
